// File: rtl/maxpool2x2_stage_if.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stage_if
//   Bundles the pool stage's controller handshake, its ReLU-buffer read port and
//   its pooled-buffer write port.
//   The parameters must match the ones used on the attached maxpool2x2_stage.
//
//   Signals
//     pool_start  controller -> stage   one-cycle start pulse
//     pool_done   stage -> controller   one-cycle completion pulse
//     busy        stage -> controller   pass in progress
//     in_addr     stage -> ReLU buffer  read address
//     in_re       stage -> ReLU buffer  read enable
//     in_data     ReLU buffer -> stage  read data, one cycle after in_re
//     out_addr    stage -> pooled buf   write address
//     out_data    stage -> pooled buf   write data
//     out_we      stage -> pooled buf   write strobe
//
//   Modports
//     master  controller/buffer side
//     slave   pool stage side
// -----------------------------------------------------------------------------
interface maxpool2x2_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IN_H       = 28,
  parameter int IN_W       = 28
);
  localparam int OUT_H  = IN_H / 2;
  localparam int OUT_W  = IN_W / 2;
  localparam int IN_N   = CHANNELS * IN_H * IN_W;
  localparam int OUT_N  = CHANNELS * OUT_H * OUT_W;
  localparam int IN_AW  = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam int OUT_AW = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  logic                         pool_start;
  logic                         pool_done;
  logic                         busy;
  logic [IN_AW-1:0]             in_addr;
  logic                         in_re;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic [OUT_AW-1:0]            out_addr;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_we;

  modport master (
    output pool_start, in_data,
    input  pool_done, busy, in_addr, in_re, out_addr, out_data, out_we
  );

  modport slave (
    input  pool_start, in_data,
    output pool_done, busy, in_addr, in_re, out_addr, out_data, out_we
  );
endinterface

// File: rtl/maxpool2x2_stage.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stage
//   2x2 / stride-2 max pooling over a CHANNELS x IN_H x IN_W feature map held
//   in a synchronous-read RAM, writing a CHANNELS x OUT_H x OUT_W map into a
//   synchronous-write RAM. One pass per pool_start pulse, ending in a
//   one-cycle pool_done pulse. Each window takes 6 cycles: 4 reads, one cycle
//   to absorb the last read's data, one write.
//
//   Ports
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset (aborts any pass in progress)
//     bus      maxpool2x2_stage_if.slave: pool_start/pool_done/busy handshake,
//              in_addr/in_re/in_data read port, out_addr/out_data/out_we
//              write port. Every output is driven straight from a flop.
//
//   Build option
//     POOL_FUSED_RELU_EN  when defined, negative window maxima are written
//                         as 0. Timing is the same in both builds.
// -----------------------------------------------------------------------------
module maxpool2x2_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IN_H       = 28,
  parameter int IN_W       = 28
) (
  input logic             clk,
  input logic             reset_n,
  maxpool2x2_stage_if.slave bus
);
  localparam int OUT_H  = IN_H / 2;
  localparam int OUT_W  = IN_W / 2;
  localparam int IN_N   = CHANNELS * IN_H * IN_W;
  localparam int OUT_N  = CHANNELS * OUT_H * OUT_W;
  localparam int IN_AW  = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam int OUT_AW = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ROW_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  // Address strides, reduced modulo 2^IN_AW; the final address always fits,
  // so the modular sum is exact.
  localparam logic [IN_AW-1:0]  PLANE_A   = IN_AW'(IN_H * IN_W);
  localparam logic [IN_AW-1:0]  ROW_A     = IN_AW'(IN_W);
  localparam logic [OUT_AW-1:0] LAST_WIN  = OUT_AW'(OUT_N - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(OUT_H - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(OUT_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LAST, S_WR, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   sub_q, sub_d;     // read slot within window
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [ROW_W-1:0]             row_q, row_d;     // output row
  logic [COL_W-1:0]             col_q, col_d;     // output column
  logic [OUT_AW-1:0]            win_q, win_d;     // output index of window
  logic signed [DATA_WIDTH-1:0] max_q, max_d;

  logic [IN_AW-1:0]             in_addr_q, in_addr_d;
  logic                         in_re_q, in_re_d;
  logic [OUT_AW-1:0]            out_addr_q, out_addr_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_we_q, out_we_d;
  logic                         pool_done_q, pool_done_d;
  logic                         busy_q, busy_d;

  logic signed [DATA_WIDTH-1:0] win_max;
  logic signed [DATA_WIDTH-1:0] out_val;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sub_q       <= '0;
      ch_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      win_q       <= '0;
      max_q       <= '0;
      in_addr_q   <= '0;
      in_re_q     <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_we_q    <= 1'b0;
      pool_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      ch_q        <= ch_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_q       <= win_d;
      max_q       <= max_d;
      in_addr_q   <= in_addr_d;
      in_re_q     <= in_re_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_we_q    <= out_we_d;
      pool_done_q <= pool_done_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and scan counters
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    ch_d    = ch_q;
    row_d   = row_q;
    col_d   = col_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (bus.pool_start) begin
          state_d = S_RD;
          sub_d   = '0;
          ch_d    = '0;
          row_d   = '0;
          col_d   = '0;
          win_d   = '0;
        end
      end
      S_RD: begin
        sub_d = sub_q + 2'd1;   // wraps to 0 after the 4th read
        if (sub_q == 2'd3) state_d = S_LAST;
      end
      S_LAST: state_d = S_WR;
      S_WR: begin
        if (win_q == LAST_WIN) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
          win_d   = win_q + 1'b1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d = '0;
              ch_d  = ch_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;   // a start pulse here is deliberately dropped
      default: state_d = S_IDLE;
    endcase
  end

  // Running max of the current window plus the candidate including in_data.
  assign win_max = (max_q > bus.in_data) ? max_q : bus.in_data;

`ifdef POOL_FUSED_RELU_EN
  assign out_val = win_max[DATA_WIDTH-1] ? '0 : win_max;
`else
  assign out_val = win_max;
`endif

  // Output logic: outputs are registered, so they are decoded from the state
  // being entered. Read data lags in_re by one cycle, so the sample issued in
  // RD slot s arrives in RD slot s+1, and the 4th one arrives in LAST.
  always_comb begin
    in_re_d     = (state_d == S_RD);
    out_we_d    = (state_d == S_WR);
    pool_done_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    in_addr_d   = in_addr_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    max_d       = max_q;

    if (state_d == S_RD) begin
      in_addr_d = IN_AW'(ch_d) * PLANE_A
                + (IN_AW'(row_d) + IN_AW'(row_d) + IN_AW'(sub_d[1])) * ROW_A
                + IN_AW'(col_d) + IN_AW'(col_d) + IN_AW'(sub_d[0]);
    end

    if (state_q == S_RD && sub_q == 2'd1) begin
      max_d = bus.in_data;                  // first sample seeds the max
    end else if (state_q == S_RD && sub_q >= 2'd2) begin
      max_d = win_max;
    end

    if (state_q == S_LAST) begin
      out_data_d = out_val;
      out_addr_d = win_q;
    end
  end

  assign bus.in_addr   = in_addr_q;
  assign bus.in_re     = in_re_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_we    = out_we_q;
  assign bus.pool_done = pool_done_q;
  assign bus.busy      = busy_q;
endmodule
